isa_sequencer: RTL and testbench
================================

Name: isa_sequencer

Overview:
- Control stage directly upstream of the 8-bit accumulator ALU.
- Fetches 9-bit instructions, decodes them, and drives the ALU's R0/Input/OP/Mode inputs.
- Owns the PC, a 16x8 register file whose entry 0 is accumulator R0, and the carry flag.
- Writes ALU results back, sequences data-memory load/store over a req/ack handshake, and resolves branch-on-zero.

Parameters:
- PC_W, 8, program-counter and instruction-address width.
- MEM_TIMEOUT, 16, maximum cycles MemReq may wait for MemAck before an error halt.

Ports:
- CLK  input  1  system clock, rising edge.
- Reset_n  input  1  asynchronous active-low reset.
- Start  input  1  one-cycle pulse; starts execution from PC=0 when in IDLE or HALT.
- InstAddr  output  PC_W  instruction ROM address; equals PC.
- InstData  input  9  ROM data, combinational from InstAddr: [8:5]=op, [4]=mode, [3:0]=idx.
- ALU_R0  output  8  always Reg[0].
- ALU_Input  output  8  operand selected by decode.
- ALU_OP  output  4  ALU opcode.
- ALU_Mode  output  1  ALU mode bit.
- ALU_Out  input  8  ALU result.
- ALU_C_out  input  1  ALU carry out.
- ALU_Zero  input  1  ALU zero flag; unused except as a debug tap.
- MemReq  output  1  data-memory request, held until ack.
- MemWe  output  1  1=store, 0=load; valid while MemReq=1.
- MemAddr  output  8  data-memory address.
- MemWData  output  8  store data.
- MemRData  input  8  load data, valid in the cycle MemAck=1.
- MemAck  input  1  single-cycle acknowledge.
- Done  output  1  high in HALT.
- Err  output  1  sticky memory-timeout flag.
- Carry  output  1  carry flag.

Behaviour:
- Reset (async, Reset_n=0):
  - State=IDLE; PC=0; IR=0; all Reg=0; Carry=0; Done=0; Err=0.
  - MemReq=0, MemWe=0, MemAddr=0, MemWData=0.
  - ALU_OP=0, ALU_Mode=0, ALU_Input=0.
  - Reset mid-operation aborts any pending memory request immediately.
- IDLE: outputs idle. Start -> FETCH with PC=0.
- FETCH (1 cycle): IR<=InstData. -> EXEC.
- EXEC (1 cycle): ALU_OP=IR.op, ALU_Mode=IR.mode. ALU_Input by op:
  - 0000 lookup: {4'b0, idx}; R0<=ALU_Out.
  - 0001 load-reg: Reg[idx]; R0<=ALU_Out.
  - 0010 add: Reg[idx]; R0<=ALU_Out; Carry<=ALU_C_out.
  - 0011 sub, 0111 shl, 1000 shr, 1001 and, 1010 xor, 1011 eq, 1100 lt, 1101 gt: Reg[idx]; R0<=ALU_Out; Carry unchanged.
  - 0100 move: Reg[idx]; Reg[idx]<=R0. idx=0 is a no-op.
  - 0101 load-mem / 0110 store-mem: no ALU writeback. MemAddr<=Reg[idx], MemWe<=op[0]^1 (store=1), MemWData<=R0. -> MEM.
  - 1111 branch-on-zero: Reg[idx] (target). If R0==0 then PC<=ALU_Out, else PC<=PC+1. -> FETCH.
  - 1110 halt: -> HALT; PC unchanged.
  - All other ops (non-memory, non-branch, non-halt): PC<=PC+1 (wraps 2^PC_W-1 -> 0); -> FETCH.
- MEM:
  - MemReq=1; address, data and MemWe held stable; wait counter increments each cycle.
  - MemAck=1: for a load, R0<=MemRData. MemReq<=0; PC<=PC+1; -> FETCH.
  - Ack in the first MEM cycle is legal (minimum 1 wait cycle).
  - Counter reaches MEM_TIMEOUT with no ack: Err<=1, MemReq<=0 -> HALT.
- HALT: Done=1. Start -> FETCH with PC=0; Err is kept, Done drops.
- Start in FETCH/EXEC/MEM is ignored.
- Latency:
  - Non-memory instruction: 2 cycles.
  - Memory instruction: 2 + wait cycles, including the ack cycle.
- Register-file reads are combinational; writes happen at the EXEC/MEM clock edge.
- Only R0, Reg[idx] (for move) and Carry change per instruction.

Test Plan:
- Reset, Start; program lookup 5, move 1, lookup 3, add 1, halt -> R0=8, Reg[1]=5, Carry=0, Done=1 after 10 cycles.
- R0=0x80, Reg[2]=0x80; add 2 -> R0=0x00, Carry=1. Next: xor 2 -> R0=0x80, Carry stays 1.
- Reg[3]=0x20; store-mem 3 with R0=0x55 -> MemReq held 4 cycles, MemWe=1, MemAddr=0x20, MemWData=0x55. Ack on cycle 4 -> PC+1. Load-mem 3 with MemRData=0xAA -> R0=0xAA.
- Reg[4]=0x10; R0=0, branch 4 -> PC=0x10. R0=1, same branch -> PC=old PC+1.
- Load-mem with MemAck never asserted -> after MEM_TIMEOUT=16 cycles Err=1, MemReq=0, Done=1. Then Start -> PC=0, Err stays 1.
- Assert Reset_n=0 during MEM wait -> MemReq drops asynchronously, state IDLE. PC at 0xFF with a non-branch op -> PC wraps to 0x00.

Source files
------------

// File: rtl/isa_sequencer.sv
// isa_sequencer: fetch/decode/execute control stage driving the 8-bit accumulator ALU,
// with register file, carry flag, data-memory handshake and branch-on-zero.
module isa_sequencer #(
  parameter int PC_W        = 8,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic            CLK,
  input  logic            Reset_n,
  input  logic            Start,
  output logic [PC_W-1:0] InstAddr,
  input  logic [8:0]      InstData,
  output logic [7:0]      ALU_R0,
  output logic [7:0]      ALU_Input,
  output logic [3:0]      ALU_OP,
  output logic            ALU_Mode,
  input  logic [7:0]      ALU_Out,
  input  logic            ALU_C_out,
  input  logic            ALU_Zero,
  output logic            MemReq,
  output logic            MemWe,
  output logic [7:0]      MemAddr,
  output logic [7:0]      MemWData,
  input  logic [7:0]      MemRData,
  input  logic            MemAck,
  output logic            Done,
  output logic            Err,
  output logic            Carry
);
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, FETCH, EXEC, MEM, HALT} state_t;
  state_t          state;
  logic [PC_W-1:0] pc;
  logic [8:0]      ir;
  logic [7:0]      regs [16];
  logic [CW-1:0]   cnt;
  logic [3:0]      op, idx;
  logic            wb, unused_zero;
  assign op          = ir[8:5];
  assign idx         = ir[3:0];
  assign wb          = op inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD};
  assign InstAddr    = pc;
  assign ALU_R0      = regs[0];
  assign unused_zero = ALU_Zero;
  // ALU controls are registered at the FETCH edge so they are stable for the whole EXEC cycle
  always_ff @(posedge CLK or negedge Reset_n)
    if (!Reset_n) begin
      state     <= IDLE;
      pc        <= '0;
      ir        <= '0;
      for (int i = 0; i < 16; i++) regs[i] <= '0;
      cnt       <= '0;
      Carry     <= 1'b0;
      Done      <= 1'b0;
      Err       <= 1'b0;
      MemReq    <= 1'b0;
      MemWe     <= 1'b0;
      MemAddr   <= '0;
      MemWData  <= '0;
      ALU_OP    <= '0;
      ALU_Mode  <= 1'b0;
      ALU_Input <= '0;
    end else
      case (state)
        IDLE: if (Start) begin
          state <= FETCH;
          pc    <= '0;
        end
        FETCH: begin
          ir        <= InstData;
          ALU_OP    <= InstData[8:5];
          ALU_Mode  <= InstData[4];
          ALU_Input <= InstData[8:5] == 4'h0 ? {4'h0, InstData[3:0]} : regs[InstData[3:0]];
          state     <= EXEC;
        end
        EXEC: begin
          state <= FETCH;
          if (wb) regs[0] <= ALU_Out;
          if (op == 4'h2) Carry <= ALU_C_out;
          if (op == 4'h4) regs[idx] <= regs[0];
          if (op == 4'h5 || op == 4'h6) begin
            MemReq   <= 1'b1;
            MemWe    <= ~op[0];
            MemAddr  <= regs[idx];
            MemWData <= regs[0];
            cnt      <= '0;
            state    <= MEM;
          end else if (op == 4'hE) begin
            Done  <= 1'b1;
            state <= HALT;
          end else if (op == 4'hF)
            pc <= regs[0] == 8'h0 ? PC_W'(ALU_Out) : pc + 1'b1;
          else
            pc <= pc + 1'b1;
        end
        MEM: if (MemAck) begin
          if (!MemWe) regs[0] <= MemRData;
          MemReq <= 1'b0;
          pc     <= pc + 1'b1;
          state  <= FETCH;
        end else if (cnt == CW'(MEM_TIMEOUT - 1)) begin
          Err    <= 1'b1;
          MemReq <= 1'b0;
          Done   <= 1'b1;
          state  <= HALT;
        end else
          cnt <= cnt + 1'b1;
        HALT: if (Start) begin
          Done  <= 1'b0;
          pc    <= '0;
          state <= FETCH;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_isa_sequencer.sv
// tb_isa_sequencer: lockstep ISA-level reference model with a behavioural ALU, ROM and memory responder.
module tb_isa_sequencer;
  localparam int MEM_TIMEOUT = 16;
  logic       CLK = 0, Reset_n = 0, Start = 0;
  logic [7:0] InstAddr, ALU_R0, ALU_Input, ALU_Out, MemAddr, MemWData, MemRData;
  logic [8:0] InstData;
  logic [3:0] ALU_OP;
  logic       ALU_Mode, ALU_C_out, ALU_Zero, MemReq, MemWe, MemAck, Done, Err, Carry;
  logic [8:0] prog [256];
  logic [7:0] m_reg [16];
  logic [7:0] m_pc;
  logic       m_carry, m_err;
  int         vectors = 0, errs = 0;
  bit         h;

  isa_sequencer #(.PC_W(8), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .CLK(CLK), .Reset_n(Reset_n), .Start(Start), .InstAddr(InstAddr), .InstData(InstData),
    .ALU_R0(ALU_R0), .ALU_Input(ALU_Input), .ALU_OP(ALU_OP), .ALU_Mode(ALU_Mode),
    .ALU_Out(ALU_Out), .ALU_C_out(ALU_C_out), .ALU_Zero(ALU_Zero),
    .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
    .MemRData(MemRData), .MemAck(MemAck), .Done(Done), .Err(Err), .Carry(Carry));

  always #5 CLK = ~CLK;

  // Stand-in ALU: returns {carry, result}; lookup with mode=1 places idx in the high nibble
  function automatic logic [8:0] alu_f(input logic [3:0] op, input logic m, input logic [7:0] a, input logic [7:0] b);
    case (op)
      4'h0: return m ? {1'b0, b[3:0], 4'h0} : {1'b0, b};
      4'h2: return {1'b0, a} + {1'b0, b};
      4'h3: return {1'b0, a} - {1'b0, b};
      4'h7: return {a, 1'b0};
      4'h8: return {a[0], 1'b0, a[7:1]};
      4'h9: return {1'b0, a & b};
      4'hA: return {1'b0, a ^ b};
      4'hB: return {8'h0, a == b};
      4'hC: return {8'h0, a < b};
      4'hD: return {8'h0, a > b};
      default: return {1'b0, b};
    endcase
  endfunction

  assign InstData              = prog[InstAddr];
  assign {ALU_C_out, ALU_Out}  = alu_f(ALU_OP, ALU_Mode, ALU_R0, ALU_Input);
  assign ALU_Zero              = ALU_Out == 8'h0;

  function automatic logic [8:0] ins(input logic [3:0] op, input logic m, input logic [3:0] idx);
    return {op, m, idx};
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = ins(4'hE, 1'b0, 4'h0);
  endtask

  task automatic do_reset();
    Reset_n = 0; Start = 0; MemAck = 0; MemRData = 0;
    repeat (2) @(posedge CLK);
    #1 Reset_n = 1;
    for (int i = 0; i < 16; i++) m_reg[i] = 8'h0;
    m_pc = 0; m_carry = 0; m_err = 0;
  endtask

  task automatic start_run();
    Start = 1;
    @(posedge CLK); #1;
    Start = 0;
    m_pc = 0;
  endtask

  // Runs one instruction from its FETCH cycle; ack_wait=0 means memory never acknowledges
  task automatic exec_instr(input int ack_wait, input logic [7:0] rdata, output bit halted);
    logic [8:0] i9, r;
    logic [3:0] op, idx;
    logic       mode;
    logic [7:0] opnd;
    halted = 0;
    i9 = prog[m_pc]; op = i9[8:5]; mode = i9[4]; idx = i9[3:0];
    vectors++;
    if (InstAddr !== m_pc) begin errs++; $display("FAIL fetch_pc: got %h want %h", InstAddr, m_pc); end
    @(posedge CLK); #1;
    opnd = (op == 4'h0) ? {4'h0, idx} : m_reg[idx];
    r = alu_f(op, mode, m_reg[0], opnd);
    vectors++;
    if ({ALU_OP, ALU_Mode, ALU_Input} !== {op, mode, opnd}) begin
      errs++; $display("FAIL exec_alu: got op=%h m=%b in=%h want op=%h m=%b in=%h", ALU_OP, ALU_Mode, ALU_Input, op, mode, opnd);
    end
    if (op == 4'h5 || op == 4'h6) begin
      @(posedge CLK); #1;
      vectors++;
      if ({MemReq, MemWe, MemAddr, MemWData} !== {1'b1, op == 4'h6, m_reg[idx], m_reg[0]}) begin
        errs++; $display("FAIL mem_req: got req=%b we=%b a=%h d=%h want we=%b a=%h d=%h", MemReq, MemWe, MemAddr, MemWData, op == 4'h6, m_reg[idx], m_reg[0]);
      end
      if (ack_wait == 0) begin
        repeat (MEM_TIMEOUT - 1) begin @(posedge CLK); #1; end
        vectors++;
        if (MemReq !== 1'b1) begin errs++; $display("FAIL mem_last_wait: req=%b want 1", MemReq); end
        @(posedge CLK); #1;
        m_err = 1; halted = 1;
      end else begin
        repeat (ack_wait - 1) begin @(posedge CLK); #1; end
        vectors++;
        if ({MemReq, MemAddr, MemWData} !== {1'b1, m_reg[idx], m_reg[0]}) begin
          errs++; $display("FAIL mem_hold: got req=%b a=%h d=%h want a=%h d=%h", MemReq, MemAddr, MemWData, m_reg[idx], m_reg[0]);
        end
        MemAck = 1; MemRData = rdata;
        @(posedge CLK); #1;
        MemAck = 0;
        if (op == 4'h5) m_reg[0] = rdata;
        m_pc = m_pc + 1;
      end
      vectors++;
      if (MemReq !== 1'b0) begin errs++; $display("FAIL mem_release: req=%b want 0", MemReq); end
    end else begin
      @(posedge CLK); #1;
      if (op == 4'hE) halted = 1;
      else if (op == 4'hF) m_pc = (m_reg[0] == 8'h0) ? r[7:0] : m_pc + 1;
      else begin
        m_pc = m_pc + 1;
        if (op == 4'h4) m_reg[idx] = m_reg[0];
        else m_reg[0] = r[7:0];
        if (op == 4'h2) m_carry = r[8];
      end
    end
    vectors++;
    if ({ALU_R0, Carry, Done, Err, InstAddr} !== {m_reg[0], m_carry, halted, m_err, m_pc}) begin
      errs++; $display("FAIL retire op=%h: got r0=%h c=%b done=%b err=%b pc=%h want r0=%h c=%b done=%b err=%b pc=%h",
        op, ALU_R0, Carry, Done, Err, InstAddr, m_reg[0], m_carry, halted, m_err, m_pc);
    end
  endtask

  task automatic test_reset();
    clear_prog();
    do_reset();
    vectors++;
    if ({InstAddr, ALU_R0, ALU_Input, ALU_OP, ALU_Mode, MemReq, MemWe, MemAddr, MemWData, Done, Err, Carry} !== '0) begin
      errs++; $display("FAIL reset_state: pc=%h r0=%h in=%h op=%h req=%b done=%b err=%b c=%b", InstAddr, ALU_R0, ALU_Input, ALU_OP, MemReq, Done, Err, Carry);
    end
    repeat (3) @(posedge CLK); #1;
    vectors++;
    if ({InstAddr, Done, MemReq} !== '0) begin errs++; $display("FAIL idle_hold: pc=%h done=%b req=%b", InstAddr, Done, MemReq); end
  endtask

  task automatic test_program();
    clear_prog();
    do_reset();
    prog[0] = ins(4'h0, 0, 4'd5); prog[1] = ins(4'h4, 0, 4'd1); prog[2] = ins(4'h0, 0, 4'd3);
    prog[3] = ins(4'h2, 0, 4'd1);
    start_run();
    for (int i = 0; i < 5; i++) exec_instr(1, 8'h0, h);
    vectors++;
    if ({ALU_R0, Carry, Done, m_reg[1]} !== {8'h08, 1'b0, 1'b1, 8'h05}) begin
      errs++; $display("FAIL program_result: got r0=%h c=%b done=%b want r0=08 c=0 done=1", ALU_R0, Carry, Done);
    end
  endtask

  task automatic test_carry();
    clear_prog();
    do_reset();
    prog[0] = ins(4'h0, 1, 4'd8); prog[1] = ins(4'h4, 0, 4'd2); prog[2] = ins(4'h2, 0, 4'd2);
    prog[3] = ins(4'hA, 0, 4'd2);
    start_run();
    for (int i = 0; i < 3; i++) exec_instr(1, 8'h0, h);
    vectors++;
    if ({ALU_R0, Carry} !== {8'h00, 1'b1}) begin errs++; $display("FAIL add_carry: got r0=%h c=%b want 00 1", ALU_R0, Carry); end
    for (int i = 0; i < 2; i++) exec_instr(1, 8'h0, h);
    vectors++;
    if ({ALU_R0, Carry} !== {8'h80, 1'b1}) begin errs++; $display("FAIL xor_keeps_carry: got r0=%h c=%b want 80 1", ALU_R0, Carry); end
  endtask

  task automatic test_mem();
    clear_prog();
    do_reset();
    prog[0] = ins(4'h0, 1, 4'd2); prog[1] = ins(4'h4, 0, 4'd3); prog[2] = ins(4'h0, 0, 4'd5);
    prog[3] = ins(4'h4, 0, 4'd4); prog[4] = ins(4'h0, 1, 4'd5); prog[5] = ins(4'h2, 0, 4'd4);
    prog[6] = ins(4'h6, 0, 4'd3); prog[7] = ins(4'h5, 0, 4'd3);
    start_run();
    for (int i = 0; i < 6; i++) exec_instr(1, 8'h0, h);
    exec_instr(4, 8'h00, h);
    exec_instr(2, 8'hAA, h);
    vectors++;
    if ({ALU_R0, InstAddr} !== {8'hAA, 8'h08}) begin errs++; $display("FAIL load_mem: got r0=%h pc=%h want AA 08", ALU_R0, InstAddr); end
    exec_instr(1, 8'h0, h);
  endtask

  task automatic test_branch();
    clear_prog();
    do_reset();
    prog[0] = ins(4'h0, 1, 4'd1); prog[1] = ins(4'h4, 0, 4'd4); prog[2] = ins(4'h0, 0, 4'd0);
    prog[3] = ins(4'hF, 0, 4'd4); prog[8'h10] = ins(4'h0, 0, 4'd1); prog[8'h11] = ins(4'hF, 0, 4'd4);
    start_run();
    for (int i = 0; i < 4; i++) exec_instr(1, 8'h0, h);
    vectors++;
    if (InstAddr !== 8'h10) begin errs++; $display("FAIL branch_taken: pc=%h want 10", InstAddr); end
    for (int i = 0; i < 2; i++) exec_instr(1, 8'h0, h);
    vectors++;
    if (InstAddr !== 8'h12) begin errs++; $display("FAIL branch_not_taken: pc=%h want 12", InstAddr); end
    exec_instr(1, 8'h0, h);
  endtask

  task automatic test_timeout();
    clear_prog();
    do_reset();
    prog[0] = ins(4'h0, 1, 4'd3); prog[1] = ins(4'h4, 0, 4'd7); prog[2] = ins(4'h5, 0, 4'd7);
    start_run();
    for (int i = 0; i < 2; i++) exec_instr(1, 8'h0, h);
    exec_instr(0, 8'h0, h);
    start_run();
    vectors++;
    if ({InstAddr, Err, Done} !== {8'h00, 1'b1, 1'b0}) begin
      errs++; $display("FAIL restart_after_err: got pc=%h err=%b done=%b want 00 1 0", InstAddr, Err, Done);
    end
  endtask

  task automatic test_reset_mid_mem();
    clear_prog();
    do_reset();
    prog[0] = ins(4'h5, 0, 4'd0);
    start_run();
    repeat (5) begin @(posedge CLK); #1; end
    vectors++;
    if (MemReq !== 1'b1) begin errs++; $display("FAIL mid_mem_wait: req=%b want 1", MemReq); end
    #2 Reset_n = 0;
    #1;
    vectors++;
    if ({MemReq, InstAddr, Done, Err} !== '0) begin
      errs++; $display("FAIL async_abort: got req=%b pc=%h done=%b err=%b want all 0", MemReq, InstAddr, Done, Err);
    end
    @(posedge CLK); #1 Reset_n = 1;
    repeat (2) @(posedge CLK); #1;
    vectors++;
    if ({MemReq, InstAddr} !== '0) begin errs++; $display("FAIL idle_after_abort: req=%b pc=%h", MemReq, InstAddr); end
  endtask

  task automatic test_wrap();
    clear_prog();
    do_reset();
    prog[0] = ins(4'h0, 0, 4'd15); prog[1] = ins(4'h4, 0, 4'd5); prog[2] = ins(4'h0, 1, 4'd15);
    prog[3] = ins(4'h2, 0, 4'd5); prog[4] = ins(4'h4, 0, 4'd6); prog[5] = ins(4'h0, 0, 4'd0);
    prog[6] = ins(4'hF, 0, 4'd6); prog[8'hFF] = ins(4'h0, 0, 4'd7);
    start_run();
    for (int i = 0; i < 7; i++) exec_instr(1, 8'h0, h);
    vectors++;
    if (InstAddr !== 8'hFF) begin errs++; $display("FAIL reach_ff: pc=%h want ff", InstAddr); end
    exec_instr(1, 8'h0, h);
    vectors++;
    if (InstAddr !== 8'h00) begin errs++; $display("FAIL pc_wrap: pc=%h want 00", InstAddr); end
    exec_instr(1, 8'h0, h);
  endtask

  task automatic test_random();
    for (int i = 0; i < 256; i++) prog[i] = 9'($urandom_range(0, 511));
    do_reset();
    start_run();
    for (int n = 0; n < 400; n++) begin
      exec_instr(int'($urandom_range(1, 5)), 8'($urandom), h);
      if (h) start_run();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_program();
    test_carry();
    test_mem();
    test_branch();
    test_timeout();
    test_reset_mid_mem();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
